e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_if.sv | 37 +++
 rtl/e_mdu.sv | 240 ++++++++++++++++++++++++
 tb/tb_e_mdu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - request/result bundle between a core and the e_mdu multiply/divide unit
//
// Signals (named from the unit's point of view):
//   i_start   1  qualifies i_mdOp for one cycle
//   i_mdOp    4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 NONE
//   i_srcA   32  rs operand / dividend / MTHI-MTLO data
//   i_srcB   32  rt operand / divisor
//   o_busy    1  multi-cycle operation in flight
//   o_done    1  one-cycle pulse after HI/LO written by MULT/DIV
//   o_div0    1  one-cycle divide-by-zero pulse (guard build only, else 0)
//   o_hi     32  architectural HI
//   o_lo     32  architectural LO
//   o_result 32  HI for MFHI, LO for MFLO, else 0 (combinational on i_mdOp)
// Modports: master drives the request side, slave is the unit.

interface e_mdu_if;
    logic        i_start;
    logic [3:0]  i_mdOp;
    logic [31:0] i_srcA;
    logic [31:0] i_srcB;
    logic        o_busy;
    logic        o_done;
    logic        o_div0;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [31:0] o_result;

    modport master (
        output i_start, i_mdOp, i_srcA, i_srcB,
        input  o_busy, o_done, o_div0, o_hi, o_lo, o_result
    );

    modport slave (
        input  i_start, i_mdOp, i_srcA, i_srcB,
        output o_busy, o_done, o_div0, o_hi, o_lo, o_result
    );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - MIPS-style HI/LO multiply/divide unit with fixed-latency MULT/DIV
//
// Ports:
//   i_clk    single clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset; clears HI/LO and discards any in-flight op
//   bus      e_mdu_if.slave: i_start/i_mdOp/i_srcA/i_srcB in,
//            o_busy/o_done/o_div0/o_hi/o_lo/o_result out
// Parameters:
//   MULT_CYCLES  multiply latency in cycles (>=1)
//   DIV_CYCLES   divide latency in cycles (>=1)
// Build option:
//   MDU_DIV0_GUARD_EN  when defined, DIV/DIVU by zero is rejected in IDLE with an
//                      o_div0 pulse; otherwise it runs like any divide and yields
//                      HI=dividend, LO=0xFFFFFFFF, and o_div0 is tied low.

module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    e_mdu_if.slave   bus
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Counter holds "edges remaining before completion", so it needs MAXC-1 at most.
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic             done_q,  done_d;
`ifdef MDU_DIV0_GUARD_EN
    logic             div0_q,  div0_d;
`endif

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        launch;

    // ------------------------------------------------------------------
    // Datapath: result of the latched operation, consumed on the final edge.
    // ------------------------------------------------------------------
    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] prod_s, prod_u;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [31:0] quo_m, rem_m;
    logic [31:0] quo_u, rem_u;

    always_comb begin
        a_sx   = {{32{a_q[31]}}, a_q};
        b_sx   = {{32{b_q[31]}}, b_q};
        a_zx   = {32'd0, a_q};
        b_zx   = {32'd0, b_q};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to
        // 0x80000000 and no signed-overflow corner reaches the divider.
        sign_a = a_q[31];
        sign_b = b_q[31];
        mag_a  = sign_a ? (~a_q + 32'd1) : a_q;
        mag_b  = sign_b ? (~b_q + 32'd1) : b_q;
        quo_m  = mag_a / mag_b;
        rem_m  = mag_a % mag_b;
        quo_u  = a_q / b_q;
        rem_u  = a_q % b_q;

        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = (sign_a ^ sign_b) ? (~quo_m + 32'd1) : quo_m;
                    res_hi = sign_a ? (~rem_m + 32'd1) : rem_m;
                end
            end
            OP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = quo_u;
                    res_hi = rem_u;
                end
            end
            default: begin
                res_hi = hi_q;
                res_lo = lo_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control: next state and register updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_DIV0_GUARD_EN
        div0_d  = 1'b0;
`endif
        launch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    case (bus.i_mdOp)
                        OP_MULT, OP_MULTU: launch = 1'b1;
                        OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV0_GUARD_EN
                            if (bus.i_srcB == 32'd0) begin
                                div0_d = 1'b1;
                            end else begin
                                launch = 1'b1;
                            end
`else
                            launch = 1'b1;
`endif
                        end
                        OP_MTHI: hi_d = bus.i_srcA;
                        OP_MTLO: lo_d = bus.i_srcA;
                        default: ;
                    endcase
                end
                if (launch) begin
                    state_d = ST_RUN;
                    op_d    = bus.i_mdOp;
                    a_d     = bus.i_srcA;
                    b_d     = bus.i_srcB;
                    cnt_d   = (bus.i_mdOp == OP_MULT || bus.i_mdOp == OP_MULTU)
                              ? MUL_LOAD : DIV_LOAD;
                end
            end
            ST_RUN: begin
                // i_start is deliberately not looked at here.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    op_d    = OP_NONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MDU_DIV0_GUARD_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MDU_DIV0_GUARD_EN
            div0_q  <= div0_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_result = 32'd0;
        case (bus.i_mdOp)
            OP_MFHI: bus.o_result = hi_q;
            OP_MFLO: bus.o_result = lo_q;
            default: bus.o_result = 32'd0;
        endcase
    end

    assign bus.o_busy = (state_q == ST_RUN);
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
`ifdef MDU_DIV0_GUARD_EN
    assign bus.o_div0 = div0_q;
`else
    assign bus.o_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed table-driven bench for e_mdu

`timescale 1ns/1ps

module tb_e_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int NVEC = 14;
    localparam int LIMIT = 200;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int n;
        int done_seen;

        checks = 0;
        errors = 0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 5,  32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{OP_MTHI,  32'h1234_5678, 32'h0000_0000, 0,  32'h1234_5678, 32'h8000_0000, 1'b0};
        vecs[6]  = '{OP_MTLO,  32'h0000_ABCD, 32'h0000_0000, 0,  32'h1234_5678, 32'h0000_ABCD, 1'b0};
        vecs[7]  = '{OP_MFHI,  32'h5555_5555, 32'h0000_0000, 0,  32'h1234_5678, 32'h0000_ABCD, 1'b0};
        vecs[8]  = '{4'd9,     32'h5555_5555, 32'h0000_0001, 0,  32'h1234_5678, 32'h0000_ABCD, 1'b0};
        vecs[9]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[10] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[12] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000, 1'b0};
`ifdef MDU_DIV0_GUARD_EN
        vecs[13] = '{OP_DIV,   32'h0000_0005, 32'h0000_0000, 0,  32'h4000_0000, 32'h0000_0000, 1'b1};
`else
        vecs[13] = '{OP_DIV,   32'h0000_0005, 32'h0000_0000, 10, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0};
`endif

        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        bus.i_srcA  = 32'd0;
        bus.i_srcB  = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_done", {31'd0, bus.o_done}, 32'd0);
        check("rst_div0", {31'd0, bus.o_div0}, 32'd0);
        check("rst_hi", bus.o_hi, 32'd0);
        check("rst_lo", bus.o_lo, 32'd0);
        rst_n = 1'b1;

        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.i_start = 1'b1;
            bus.i_mdOp  = vecs[i].op;
            bus.i_srcA  = vecs[i].a;
            bus.i_srcB  = vecs[i].b;
            @(posedge clk);
            #1;
            // Scramble inputs after acceptance: the result must come from the latched copy.
            bus.i_start = 1'b0;
            bus.i_mdOp  = OP_NONE;
            bus.i_srcA  = 32'hDEAD_BEEF;
            bus.i_srcB  = 32'h0000_0000;
            @(negedge clk);
            check($sformatf("v%0d_div0", i), {31'd0, bus.o_div0}, {31'd0, vecs[i].div0});
            n = 0;
            while (bus.o_busy && n < LIMIT) begin
                n++;
                check($sformatf("v%0d_hold_hi", i), bus.o_hi, prev_hi);
                check($sformatf("v%0d_hold_lo", i), bus.o_lo, prev_lo);
                @(negedge clk);
            end
            check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].cycles));
            check($sformatf("v%0d_done", i), {31'd0, bus.o_done}, (vecs[i].cycles > 0) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_hi", i), bus.o_hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), bus.o_lo, vecs[i].lo);
            @(negedge clk);
            check($sformatf("v%0d_done_off", i), {31'd0, bus.o_done}, 32'd0);
            check($sformatf("v%0d_div0_off", i), {31'd0, bus.o_div0}, 32'd0);
            bus.i_mdOp = OP_MFHI;
            #1;
            check($sformatf("v%0d_mfhi", i), bus.o_result, vecs[i].hi);
            bus.i_mdOp = OP_MFLO;
            #1;
            check($sformatf("v%0d_mflo", i), bus.o_result, vecs[i].lo);
            bus.i_mdOp = OP_MULT;
            #1;
            check($sformatf("v%0d_result_zero", i), bus.o_result, 32'd0);
            bus.i_mdOp = OP_NONE;
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // MTHI and a second MULT issued mid-RUN must be ignored entirely.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_mdOp  = OP_MULT;
        bus.i_srcA  = 32'd3;
        bus.i_srcB  = 32'd4;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        @(negedge clk);
        n = 0;
        while (bus.o_busy && n < LIMIT) begin
            n++;
            bus.i_start = 1'b0;
            bus.i_mdOp  = OP_NONE;
            if (n == 2) begin
                bus.i_start = 1'b1;
                bus.i_mdOp  = OP_MTHI;
                bus.i_srcA  = 32'h1234_5678;
            end else if (n == 3) begin
                bus.i_start = 1'b1;
                bus.i_mdOp  = OP_MULT;
                bus.i_srcA  = 32'd100;
                bus.i_srcB  = 32'd100;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        check("run_ign_cycles", 32'(n), 32'd5);
        check("run_ign_done", {31'd0, bus.o_done}, 32'd1);
        check("run_ign_hi", bus.o_hi, 32'd0);
        check("run_ign_lo", bus.o_lo, 32'd12);
        @(negedge clk);
        check("run_ign_idle", {31'd0, bus.o_busy}, 32'd0);
        bus.i_start = 1'b1;
        bus.i_mdOp  = OP_MTHI;
        bus.i_srcA  = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        check("mthi_idle_hi", bus.o_hi, 32'h1234_5678);
        check("mthi_idle_busy", {31'd0, bus.o_busy}, 32'd0);
        @(negedge clk);
        check("mthi_idle_busy2", {31'd0, bus.o_busy}, 32'd0);
        check("mthi_idle_done", {31'd0, bus.o_done}, 32'd0);

        // Reset in the third busy cycle of a DIV discards the op and clears HI/LO at once.
        bus.i_start = 1'b1;
        bus.i_mdOp  = OP_DIV;
        bus.i_srcA  = 32'd100;
        bus.i_srcB  = 32'd7;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        repeat (3) @(negedge clk);
        check("mid_busy_before", {31'd0, bus.o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("mid_rst_hi", bus.o_hi, 32'd0);
        check("mid_rst_lo", bus.o_lo, 32'd0);
        check("mid_rst_done", {31'd0, bus.o_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_start = 1'b1;
        bus.i_mdOp  = OP_MTLO;
        bus.i_srcA  = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_mdOp  = OP_NONE;
        check("post_rst_first_lo", bus.o_lo, 32'h0000_0055);
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) done_seen++;
        end
        check("post_rst_no_done", 32'(done_seen), 32'd0);
        check("post_rst_hi", bus.o_hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
